uart_tx_cfg: RTL

Parametrised UART transmitter, the successor to the fixed 8-bit serializer/parity/FSM/mux transmitter.
- Adds configurable data width, an internal baud prescaler (clocks per bit), and 1 or 2 stop bits.
- Latches data and frame configuration at accept, so changes during a frame have no effect.
- Sits on the TX clock domain, fed by the sync-FIFO/data-sync stage of the system.

---
 rtl/uart_tx_pkg.sv | 25 ++
 rtl/uart_tx_cfg_if.sv | 27 ++
 rtl/uart_tx_bit_timer.sv | 35 +++
 rtl/uart_tx_cfg.sv | 133 +++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Provides the frame FSM encoding, parity-type codes and the bit-index width helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int BIT_IDX_W      = $clog2(DEF_DATA_WIDTH);

    // Index width for an arbitrary data width; never narrower than one bit.
    function automatic int idx_width(input int dw);
        return (dw <= 1) ? 1 : $clog2(dw);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Request/config bundle and serial output of the UART transmitter.
// A word is accepted on the rising edge where DATA_Valid=1 and busy=0; busy is the inverse of ready.
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic                  TX_OUT;
    logic                  busy;
    uart_tx_pkg::state_t   fsm_state;

    modport master (
        output P_DATA, DATA_Valid, PAR_EN, PAR_TYP, STOP2, PRESCALE,
        input  TX_OUT, busy, fsm_state
    );

    modport slave (
        input  P_DATA, DATA_Valid, PAR_EN, PAR_TYP, STOP2, PRESCALE,
        output TX_OUT, busy, fsm_state
    );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Clocks-per-bit counter: load latches the period (0 treated as 1), clear parks the count,
// and bit_done flags the last cycle of the current bit.
module uart_tx_bit_timer #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_done
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] period_q;

    assign bit_done = (cnt_q == period_q - PRESCALE_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= PRESCALE_W'(1);
        end else if (load) begin
            cnt_q    <= '0;
            period_q <= (prescale == '0) ? PRESCALE_W'(1) : prescale;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (bit_done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, LSB-first data, optional parity, one or two stop bits.
// Data and frame configuration are captured at accept so the frame is immune to input changes.
module uart_tx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_cfg_if.slave  bus
);
    import uart_tx_pkg::*;

    localparam int IDX_W = idx_width(DATA_WIDTH);

    state_t                state_q, state_n;
    logic                  tx_q, tx_n;
    logic                  busy_q, busy_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic [IDX_W-1:0]      idx_q, idx_n;
    logic                  par_en_q, par_en_n;
    logic                  stop2_q, stop2_n;
    logic                  par_bit_q, par_bit_n;
    logic                  load;
    logic                  bit_done;

    uart_tx_bit_timer #(.PRESCALE_W(PRESCALE_W)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (load),
        .clear    (state_q == IDLE),
        .prescale (bus.PRESCALE),
        .bit_done (bit_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            idx_q     <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            tx_q      <= tx_n;
            busy_q    <= busy_n;
            shift_q   <= shift_n;
            idx_q     <= idx_n;
            par_en_q  <= par_en_n;
            stop2_q   <= stop2_n;
            par_bit_q <= par_bit_n;
        end
    end

    // Outputs are registered: each branch sets the line level for the bit that starts next.
    always_comb begin
        state_n   = state_q;
        tx_n      = tx_q;
        busy_n    = busy_q;
        shift_n   = shift_q;
        idx_n     = idx_q;
        par_en_n  = par_en_q;
        stop2_n   = stop2_q;
        par_bit_n = par_bit_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                tx_n = 1'b1;
                if (bus.DATA_Valid) begin
                    load      = 1'b1;
                    state_n   = START;
                    tx_n      = 1'b0;
                    busy_n    = 1'b1;
                    shift_n   = bus.P_DATA;
                    idx_n     = '0;
                    par_en_n  = bus.PAR_EN;
                    stop2_n   = bus.STOP2;
                    par_bit_n = (bus.PAR_TYP == ODD) ? ~^bus.P_DATA : ^bus.P_DATA;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n = DATA;
                    tx_n    = shift_q[0];
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_n = par_en_q ? PARITY : STOP1;
                        tx_n    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        idx_n   = idx_q + IDX_W'(1);
                        tx_n    = shift_q[1];
                        shift_n = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_n = STOP1;
                    tx_n    = 1'b1;
                end
            end
            STOP1: begin
                if (bit_done) begin
                    state_n = stop2_q ? STOP2 : IDLE;
                    busy_n  = stop2_q;
                end
            end
            STOP2: begin
                if (bit_done) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.TX_OUT    = tx_q;
    assign bus.busy      = busy_q;
    assign bus.fsm_state = state_q;

endmodule
